// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS program-counter stage.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } pc_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC candidate generation and select for the PC stage.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the consumer decides whether the result is committed.
module pc_next_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] imm_ext,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [31:0] next_pc
);

    logic        taken;
    logic [31:0] jump_addr;
    pc_sel_t     sel;

    assign pc_plus4      = pc + PC_STEP;
    // Word offset; the top two immediate bits fall off the 32-bit sum anyway.
    assign branch_target = pc_plus4 + (imm_ext << 2);
    assign jump_addr     = {pc_plus4[31:28], jtarget, 2'b00};
    assign taken         = (branch_eq & zero) | (branch_ne & ~zero);

    always_comb begin
        sel = SEL_SEQ;
        if (jump_reg) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        next_pc = pc_plus4;
        case (sel)
            SEL_BR:  next_pc = branch_target;
            SEL_J:   next_pc = jump_addr;
            SEL_JR:  next_pc = rs_data;
            default: next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// PC register, run/halt/fault FSM and retired-instruction counter.
// Latency: one edge per committed instruction; next PC visible after that edge.
// Backpressure: imem_ready=0 or en=0 stalls pc and counter; HALTED/FAULT hold until reset.
module pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             imem_ready,
    input  logic             branch_eq,
    input  logic             branch_ne,
    input  logic             zero,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [31:0]      imm_ext,
    input  logic [25:0]      jtarget,
    input  logic [31:0]      rs_data,
    input  logic             halt,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      branch_target,
    output logic             retire,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] retire_count
);

    pc_state_t        state_q;
    pc_state_t        state_d;
    logic [31:0]      next_pc;
    logic [31:0]      pc_d;
    logic [CNT_W-1:0] cnt_d;

    pc_next_logic u_next (
        .pc            (pc),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .imm_ext       (imm_ext),
        .jtarget       (jtarget),
        .rs_data       (rs_data),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    assign retire     = (state_q == RUN) & en & imem_ready;
    assign halted     = (state_q == HALTED);
    assign misaligned = (state_q == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt and fault both still count the offending instruction as retired.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cnt_d   = retire_count;
        if (retire) begin
            cnt_d = retire_count + CNT_W'(1);
            if (halt) begin
                state_d = HALTED;
            end else if (next_pc[1:0] != 2'b00) begin
                state_d = FAULT;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            retire_count <= '0;
        end else begin
            pc           <= pc_d;
            retire_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized bench for pc_unit against a behavioural reference model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        imem_ready = 1'b0;
    logic        branch_eq = 1'b0;
    logic        branch_ne = 1'b0;
    logic        zero = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic [31:0] imm_ext = '0;
    logic [25:0] jtarget = '0;
    logic [31:0] rs_data = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic        retire;
    logic        halted;
    logic        misaligned;
    logic [31:0] retire_count;

    pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .imem_ready    (imem_ready),
        .branch_eq     (branch_eq),
        .branch_ne     (branch_ne),
        .zero          (zero),
        .jump          (jump),
        .jump_reg      (jump_reg),
        .imm_ext       (imm_ext),
        .jtarget       (jtarget),
        .rs_data       (rs_data),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .retire        (retire),
        .halted        (halted),
        .misaligned    (misaligned),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC, retired count, terminal flags.
    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_cnt = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_fault  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit e, input bit rdy, input bit beq, input bit bne, input bit z,
                        input bit j, input bit jr, input bit h, input logic [31:0] imm,
                        input logic [25:0] jt, input logic [31:0] rs);
        logic [31:0] p4;
        logic [31:0] bt;
        logic [31:0] np;
        bit          tk;
        bit          ret;
        en = e; imem_ready = rdy; branch_eq = beq; branch_ne = bne; zero = z;
        jump = j; jump_reg = jr; halt = h; imm_ext = imm; jtarget = jt; rs_data = rs;
        p4  = m_pc + 32'd4;
        bt  = p4 + imm * 32'd4;
        tk  = (beq && z) || (bne && !z);
        if (jr)      np = rs;
        else if (j)  np = (p4 & 32'hF000_0000) | ({6'b0, jt} << 2);
        else if (tk) np = bt;
        else         np = p4;
        ret = e && rdy && !m_halted && !m_fault;
        #2;
        chk("retire", {31'b0, retire}, {31'b0, ret});
        chk("pc_plus4", pc_plus4, p4);
        chk("branch_target", branch_target, bt);
        @(posedge clk);
        #1;
        if (ret) begin
            m_cnt = m_cnt + 32'd1;
            if (h)                 m_halted = 1'b1;
            else if (np % 4 != 0)  m_fault  = 1'b1;
            else                   m_pc     = np;
        end
        chk("pc", pc, m_pc);
        chk("retire_count", retire_count, m_cnt);
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("misaligned", {31'b0, misaligned}, {31'b0, m_fault});
    endtask

    task automatic seq_step();
        step(1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic goto(input logic [31:0] addr);
        step(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, addr);
    endtask

    // Reset asserted between clock edges must act immediately.
    task automatic reset_mid();
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        m_pc = 32'h0; m_cnt = 32'h0; m_halted = 1'b0; m_fault = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_count", retire_count, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #12;
        chk("init_pc", pc, 32'h0);
        chk("init_count", retire_count, 32'h0);
        chk("init_halted", {31'b0, halted}, 32'h0);
        chk("init_misaligned", {31'b0, misaligned}, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch from reset.
        seq_step(); seq_step(); seq_step();
        chk("seq_pc12", pc, 32'd12);
        chk("seq_count3", retire_count, 32'd3);

        // Branches around 0x100.
        goto(32'h100);
        step(1, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0);
        chk("beq_taken", pc, 32'hFC);
        goto(32'h100);
        step(1, 1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFE, 26'h0, 32'h0);
        chk("beq_not_taken", pc, 32'h104);
        goto(32'h100);
        step(1, 1, 0, 1, 0, 0, 0, 0, 32'h3, 26'h0, 32'h0);
        chk("bne_taken", pc, 32'h110);
        goto(32'h100);
        step(1, 1, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 26'h0, 32'h0);
        chk("beq_self_loop", pc, 32'h100);

        // Priority: jump over branch, jump_reg over jump.
        goto(32'h4000_0010);
        step(1, 1, 1, 0, 1, 1, 0, 0, 32'h5, 26'h000_0040, 32'h0);
        chk("jump_beats_branch", pc, 32'h4000_0100);
        step(1, 1, 1, 0, 1, 1, 1, 0, 32'h5, 26'h000_0040, 32'h200);
        chk("jr_beats_jump", pc, 32'h200);

        // Instruction-memory stall.
        goto(32'h20);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0);
        chk("stall_pc", pc, 32'h20);
        seq_step();
        chk("stall_release", pc, 32'h24);

        // Wrap at top of address space.
        goto(32'hFFFF_FFFC);
        seq_step();
        chk("pc_wrap", pc, 32'h0);

        // Random traffic with no halt and aligned jr targets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'b0,
                 $urandom, 26'($urandom), ($urandom & 32'hFFFF_FFFC));
        end

        // Halt is terminal and counted.
        goto(32'h30);
        begin
            logic [31:0] cnt_before;
            cnt_before = retire_count;
            step(1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0);
            chk("halt_pc", pc, 32'h30);
            chk("halt_counted", retire_count, cnt_before + 32'd1);
            chk("halt_flag", {31'b0, halted}, 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, $urandom_range(0, 1), 0, 1, $urandom_range(0, 1), 1, 0,
                 $urandom, 26'($urandom), 32'h400);
        end
        reset_mid();

        // Misaligned jr faults, then reset clears it.
        seq_step();
        step(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h202);
        chk("fault_flag", {31'b0, misaligned}, 32'h1);
        chk("fault_pc_hold", pc, 32'h4);
        chk("fault_counted", retire_count, 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h800);
        end
        reset_mid();
        seq_step();
        chk("post_reset_pc", pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
